// File: rtl/mem_bridge_pkg.sv
// Shared definitions for the CPU-to-bus memory request bridge:
// FSM state encoding, bus size codes and a lane-count-to-size helper.
package mem_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } bridge_state_t;

    localparam logic [2:0] SZ_BYTE  = 3'd0;
    localparam logic [2:0] SZ_HALF  = 3'd1;
    localparam logic [2:0] SZ_WORD  = 3'd2;
    localparam logic [2:0] SZ_DWORD = 3'd3;

    // Size code of a full-width access for a given number of byte lanes.
    function automatic logic [2:0] lanes_to_size(input int nb);
        logic [2:0] sz;
        case (nb)
            1:       sz = SZ_BYTE;
            2:       sz = SZ_HALF;
            4:       sz = SZ_WORD;
            8:       sz = SZ_DWORD;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/mem_size_enc.sv
// Byte-enable decoder: turns a byte write-enable vector into the bus write
// flag and the log2 access size. Only contiguous, naturally aligned
// power-of-two lane groups get a narrow size; reads (all-zero enables) and
// any other pattern are issued as full-width accesses.
module mem_size_enc
    import mem_bridge_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic [NB-1:0] wen,
    output logic          wr,
    output logic [2:0]    size
);

    localparam int LOG_NB = $clog2(NB);

    logic [NB-1:0] mask_s;

    // Compare the enables against every aligned lane group narrower than the bus.
    always_comb begin
        wr     = |wen;
        size   = lanes_to_size(NB);
        mask_s = '0;
        for (int k = 0; k < LOG_NB; k++) begin
            for (int j = 0; j < (NB >> k); j++) begin
                for (int b = 0; b < NB; b++) begin
                    mask_s[b] = (b >= (j << k)) && (b < ((j + 1) << k));
                end
                size = (wen == mask_s) ? 3'(k) : size;
            end
        end
    end

endmodule

// File: rtl/mem_req_bridge.sv
// Bridges a stalling CPU load/store port onto a split address/data bus.
// One access at a time: IDLE latches the request, REQ presents it until
// addr_ok, WAIT holds until data_ok, DONE releases the pipeline for one cycle.
// Optional watchdog: define MEM_BRIDGE_TIMEOUT_EN to abort an access that
// spends TIMEOUT_CYC cycles in REQ/WAIT (err pulse, cpu_rdata cleared).
module mem_req_bridge
    import mem_bridge_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_en,
    input  logic [DATA_W/8-1:0] cpu_wen,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                cpu_stall,
    output logic                req,
    output logic                wr,
    output logic [2:0]          size,
    output logic [ADDR_W-1:0]   addr,
    output logic [DATA_W-1:0]   wdata,
    input  logic                addr_ok,
    input  logic                data_ok,
    input  logic [DATA_W-1:0]   rdata,
    output logic                err
);

    localparam int NB = DATA_W / 8;

    bridge_state_t       state_r;
    logic                req_r;
    logic                wr_r;
    logic [2:0]          size_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [DATA_W-1:0]   rdata_r;

    logic                enc_wr_s;
    logic [2:0]          enc_size_s;
    logic                busy_s;
    logic                xfer_done_s;
    logic                tmo_fire_s;

    mem_size_enc #(
        .NB (NB)
    ) u_size_enc (
        .wen  (cpu_wen),
        .wr   (enc_wr_s),
        .size (enc_size_s)
    );

    // Bus-side completion and activity flags for the current state.
    always_comb begin
        busy_s      = (state_r == ST_REQ) || (state_r == ST_WAIT);
        xfer_done_s = ((state_r == ST_REQ) && addr_ok && data_ok) ||
                      ((state_r == ST_WAIT) && data_ok);
    end

`ifdef MEM_BRIDGE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1) + 1;

    logic [TMO_W-1:0] tmo_cnt_r;
    logic             err_r;

    // Watchdog fires on the last allowed REQ/WAIT cycle unless the bus completes.
    always_comb begin
        if (busy_s && !xfer_done_s && (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 1))) begin
            tmo_fire_s = 1'b1;
        end else begin
            tmo_fire_s = 1'b0;
        end
    end

    // Cycle counter for REQ/WAIT, restarted whenever a new access is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_r <= '0;
        end else if ((state_r == ST_IDLE) && cpu_en) begin
            tmo_cnt_r <= '0;
        end else if (busy_s) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    // One-cycle error pulse coinciding with the DONE cycle of an aborted access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else begin
            err_r <= tmo_fire_s;
        end
    end

    assign err = err_r;
`else
    assign tmo_fire_s = 1'b0;
    assign err        = 1'b0;
`endif

    // Request FSM with registered bus-side outputs and load data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            req_r   <= 1'b0;
            wr_r    <= 1'b0;
            size_r  <= 3'd0;
            addr_r  <= '0;
            wdata_r <= '0;
            rdata_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cpu_en) begin
                        addr_r  <= cpu_addr;
                        wdata_r <= cpu_wdata;
                        wr_r    <= enc_wr_s;
                        size_r  <= enc_size_s;
                        req_r   <= 1'b1;
                        state_r <= ST_REQ;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (addr_ok && data_ok) begin
                        req_r   <= 1'b0;
                        rdata_r <= wr_r ? rdata_r : rdata;
                        state_r <= ST_DONE;
                    end else if (addr_ok) begin
                        req_r   <= 1'b0;
                        state_r <= ST_WAIT;
                    end else if (tmo_fire_s) begin
                        req_r   <= 1'b0;
                        rdata_r <= '0;
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (data_ok) begin
                        rdata_r <= wr_r ? rdata_r : rdata;
                        state_r <= ST_DONE;
                    end else if (tmo_fire_s) begin
                        rdata_r <= '0;
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    req_r   <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_stall = cpu_en & (state_r != ST_DONE);
    assign cpu_rdata = rdata_r;
    assign req       = req_r;
    assign wr        = wr_r;
    assign size      = size_r;
    assign addr      = addr_r;
    assign wdata     = wdata_r;

endmodule

// File: tb/tb_mem_req_bridge.sv
// Directed bench for mem_req_bridge (DATA_W=32, TIMEOUT_CYC=8).
module tb_mem_req_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        req;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        err;

    int checks = 0;
    int errors = 0;

    mem_req_bridge #(
        .DATA_W      (32),
        .ADDR_W      (32),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_en    (cpu_en),
        .cpu_wen   (cpu_wen),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .req       (req),
        .wr        (wr),
        .size      (size),
        .addr      (addr),
        .wdata     (wdata),
        .addr_ok   (addr_ok),
        .data_ok   (data_ok),
        .rdata     (rdata),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_en = 1'b1; cpu_wen = 4'h0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h0;
        tick(); tick();
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", req); end
        checks++; if (wr !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b expected 0", wr); end
        checks++; if (size !== 3'd0) begin errors++; $display("FAIL reset_size: got %0d expected 0", size); end
        checks++; if (addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", addr); end
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", cpu_rdata); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL reset_stall_en: got %b expected 1", cpu_stall); end
        cpu_en = 1'b0; #1;
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall_noen: got %b expected 0", cpu_stall); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read();
        cpu_en = 1'b1; cpu_wen = 4'h0; cpu_addr = 32'h0000_1000; #1;
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL read_stall_c0: got %b expected 1", cpu_stall); end
        tick();
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL read_req_c1: got %b expected 1", req); end
        checks++; if (addr !== 32'h0000_1000) begin errors++; $display("FAIL read_addr: got %h expected 00001000", addr); end
        checks++; if (wr !== 1'b0) begin errors++; $display("FAIL read_wr: got %b expected 0", wr); end
        checks++; if (size !== 3'd2) begin errors++; $display("FAIL read_size: got %0d expected 2", size); end
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL read_stall_c1: got %b expected 1", cpu_stall); end
        addr_ok = 1'b1;
        tick();
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL read_req_c2: got %b expected 0", req); end
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL read_stall_c2: got %b expected 1", cpu_stall); end
        addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'hDEAD_BEEF;
        tick();
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL read_stall_c3: got %b expected 0", cpu_stall); end
        checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_rdata: got %h expected deadbeef", cpu_rdata); end
        data_ok = 1'b0; cpu_en = 1'b0; rdata = 32'h0;
        tick();
        checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_rdata_hold: got %h expected deadbeef", cpu_rdata); end
    endtask

    task automatic do_store(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] exp_size, input logic [31:0] keep);
        cpu_en = 1'b1; cpu_wen = w; cpu_addr = a; cpu_wdata = d;
        tick();
        cpu_wen = 4'h0; cpu_addr = 32'hFFFF_FFFF; cpu_wdata = 32'h0;
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL store_req wen=%b: got %b expected 1", w, req); end
        checks++; if (wr !== 1'b1) begin errors++; $display("FAIL store_wr wen=%b: got %b expected 1", w, wr); end
        checks++; if (size !== exp_size) begin errors++; $display("FAIL store_size wen=%b: got %0d expected %0d", w, size, exp_size); end
        checks++; if (addr !== a) begin errors++; $display("FAIL store_addr wen=%b: got %h expected %h", w, addr, a); end
        checks++; if (wdata !== d) begin errors++; $display("FAIL store_wdata wen=%b: got %h expected %h", w, wdata, d); end
        addr_ok = 1'b1;
        tick();
        addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h5555_5555;
        tick();
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL store_done wen=%b: got stall %b expected 0", w, cpu_stall); end
        checks++; if (cpu_rdata !== keep) begin errors++; $display("FAIL store_rdata_keep wen=%b: got %h expected %h", w, cpu_rdata, keep); end
        data_ok = 1'b0; cpu_en = 1'b0;
        tick();
    endtask

    task automatic test_stores();
        do_store(4'b0100, 32'h0000_2002, 32'h00AA_0000, 3'd0, 32'hDEAD_BEEF);
        do_store(4'b1100, 32'h0000_2002, 32'hBBBB_0000, 3'd1, 32'hDEAD_BEEF);
        do_store(4'b0101, 32'h0000_2000, 32'h00CC_00CC, 3'd2, 32'hDEAD_BEEF);
        do_store(4'b0011, 32'h0000_2000, 32'h0000_DDDD, 3'd1, 32'hDEAD_BEEF);
        do_store(4'b0110, 32'h0000_2001, 32'h00EE_EE00, 3'd2, 32'hDEAD_BEEF);
        do_store(4'b1000, 32'h0000_2003, 32'h1100_0000, 3'd0, 32'hDEAD_BEEF);
        do_store(4'b1111, 32'h0000_2000, 32'h1234_5678, 3'd2, 32'hDEAD_BEEF);
    endtask

    task automatic test_same_cycle();
        cpu_en = 1'b1; cpu_wen = 4'h0; cpu_addr = 32'h0000_3000;
        tick();
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL same_req: got %b expected 1", req); end
        addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'h1234_5678;
        tick();
        addr_ok = 1'b0; data_ok = 1'b0;
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL same_done_c2: got stall %b expected 0", cpu_stall); end
        checks++; if (cpu_rdata !== 32'h1234_5678) begin errors++; $display("FAIL same_rdata: got %h expected 12345678", cpu_rdata); end
        cpu_en = 1'b0;
        tick();
    endtask

    task automatic test_delayed();
        int req_cycles = 0;
        int stall_low = 0;
        cpu_en = 1'b1; cpu_wen = 4'h0; cpu_addr = 32'h0000_4000;
        for (int c = 1; c <= 8; c++) begin
            tick();
            addr_ok = 1'b0; data_ok = 1'b0;
            if (req === 1'b1) req_cycles++;
            if (cpu_stall !== 1'b1) stall_low++;
            if (c == 5) addr_ok = 1'b1;
            if (c == 8) begin data_ok = 1'b1; rdata = 32'h0F0F_0F0F; end
        end
        tick();
        addr_ok = 1'b0; data_ok = 1'b0;
        checks++; if (req_cycles != 5) begin errors++; $display("FAIL delay_req_len: got %0d expected 5", req_cycles); end
        checks++; if (stall_low != 0) begin errors++; $display("FAIL delay_stall_held: got %0d low cycles expected 0", stall_low); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL delay_done_c9: got stall %b expected 0", cpu_stall); end
        checks++; if (cpu_rdata !== 32'h0F0F_0F0F) begin errors++; $display("FAIL delay_rdata: got %h expected 0f0f0f0f", cpu_rdata); end
        tick();
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL delay_single_done: got stall %b expected 1", cpu_stall); end
        tick();
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL delay_restart_req: got %b expected 1", req); end
        addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'hA5A5_A5A5;
        tick();
        addr_ok = 1'b0; data_ok = 1'b0; cpu_en = 1'b0;
        checks++; if (cpu_rdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL delay_restart_rdata: got %h expected a5a5a5a5", cpu_rdata); end
        tick();
    endtask

`ifdef MEM_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        int err_early = 0;
        int req_cycles = 0;
        cpu_en = 1'b1; cpu_wen = 4'h0; cpu_addr = 32'h0000_5000;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (req === 1'b1) req_cycles++;
            if (err !== 1'b0) err_early++;
        end
        checks++; if (req_cycles != 8) begin errors++; $display("FAIL tmo_req_len: got %0d expected 8", req_cycles); end
        checks++; if (err_early != 0) begin errors++; $display("FAIL tmo_err_early: got %0d expected 0", err_early); end
        tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err_pulse: got %b expected 1", err); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL tmo_done: got stall %b expected 0", cpu_stall); end
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL tmo_rdata: got %h expected 0", cpu_rdata); end
        cpu_en = 1'b0;
        tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo_err_single: got %b expected 0", err); end
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL tmo_idle_req: got %b expected 0", req); end
    endtask
`else
    task automatic test_no_timeout();
        int err_seen = 0;
        cpu_en = 1'b1; cpu_wen = 4'h0; cpu_addr = 32'h0000_5000;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (err !== 1'b0) err_seen++;
        end
        checks++; if (err_seen != 0) begin errors++; $display("FAIL notmo_err: got %0d pulses expected 0", err_seen); end
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL notmo_req: got %b expected 1", req); end
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL notmo_stall: got %b expected 1", cpu_stall); end
        addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'h0BAD_F00D;
        tick();
        addr_ok = 1'b0; data_ok = 1'b0; cpu_en = 1'b0;
        checks++; if (cpu_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL notmo_rdata: got %h expected 0badf00d", cpu_rdata); end
        tick();
    endtask
`endif

    task automatic test_reset_mid();
        cpu_en = 1'b1; cpu_wen = 4'b1111; cpu_addr = 32'h0000_2000; cpu_wdata = 32'hCAFE_F00D;
        tick();
        addr_ok = 1'b1;
        tick();
        addr_ok = 1'b0;
        checks++; if (wr !== 1'b1) begin errors++; $display("FAIL mid_pre_wr: got %b expected 1", wr); end
        #2 rst = 1'b1;
        #1;
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL mid_req: got %b expected 0", req); end
        checks++; if (wr !== 1'b0) begin errors++; $display("FAIL mid_wr: got %b expected 0", wr); end
        checks++; if (size !== 3'd0) begin errors++; $display("FAIL mid_size: got %0d expected 0", size); end
        checks++; if (addr !== 32'h0) begin errors++; $display("FAIL mid_addr: got %h expected 0", addr); end
        checks++; if (wdata !== 32'h0) begin errors++; $display("FAIL mid_wdata: got %h expected 0", wdata); end
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL mid_rdata: got %h expected 0", cpu_rdata); end
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL mid_stall: got %b expected 1", cpu_stall); end
        tick();
        rst = 1'b0; cpu_en = 1'b0; data_ok = 1'b1; rdata = 32'hFFFF_FFFF;
        tick();
        data_ok = 1'b0;
        tick();
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL mid_late_data: got %h expected 0", cpu_rdata); end
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL mid_late_req: got %b expected 0", req); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_stores();
        test_same_cycle();
        test_delayed();
`ifdef MEM_BRIDGE_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
